// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with valid/ready request and result handshakes.
//
// Each operand comes from one of four sources, chosen per request:
//   0 reg_din0, 1 im_din, 2 pc_din, 3 reg_din1.
//
// Operations:
//   * Single-cycle ops (ADD..SLTU, reserved codes) are computed
//     combinationally. The result is registered into alu_out on the
//     acceptance edge.
//   * MUL runs a shift-add multiplier for exactly WIDTH iterations.
//   * Only one request is in flight at a time.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block can accept a request (registered, depends on state only)
//   op         operation code (see OP_* below)
//   num1_cs    operand-1 source select
//   num2_cs    operand-2 source select
//   pc_din     program counter
//   im_din     immediate
//   reg_din0   register read port 0
//   reg_din1   register read port 1
//   out_valid  alu_out holds a result (registered)
//   out_ready  consumer takes the result
//   alu_out    registered result
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [1:0]       num1_cs,
  input  logic [1:0]       num2_cs,
  input  logic [WIDTH-1:0] pc_din,
  input  logic [WIDTH-1:0] im_din,
  input  logic [WIDTH-1:0] reg_din0,
  input  logic [WIDTH-1:0] reg_din1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Terminal value of the multiply iteration counter.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;

  // Multiplier datapath registers.
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplr_reg;
  logic [SHW-1:0]   cnt_reg;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;

  always_comb begin
    num1 = reg_din0;
    case (num1_cs)
      2'd0:    num1 = reg_din0;
      2'd1:    num1 = im_din;
      2'd2:    num1 = pc_din;
      default: num1 = reg_din1;
    endcase
  end

  always_comb begin
    num2 = reg_din0;
    case (num2_cs)
      2'd0:    num2 = reg_din0;
      2'd1:    num2 = im_din;
      2'd2:    num2 = pc_din;
      default: num2 = reg_din1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle result
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_result;
  logic             lt_signed;
  logic             lt_unsigned;

  assign sh          = num2[SHW-1:0];
  assign lt_signed   = $signed(num1) < $signed(num2);
  assign lt_unsigned = num1 < num2;

  always_comb begin
    sc_result = '0;
    case (op)
      OP_ADD:  sc_result = num1 + num2;
      OP_SUB:  sc_result = num1 - num2;
      OP_AND:  sc_result = num1 & num2;
      OP_OR:   sc_result = num1 | num2;
      OP_XOR:  sc_result = num1 ^ num2;
      OP_SLL:  sc_result = num1 << sh;
      OP_SRL:  sc_result = num1 >> sh;
      OP_SRA:  sc_result = $signed(num1) >>> sh;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      // MUL is produced by the iterative path. Reserved codes return zero.
      default: sc_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add step.
  //
  // The partial sum for the current multiplier bit is formed here. On the
  // last iteration it is written straight into alu_out. That keeps the MUL
  // latency at WIDTH+1 edges, with no extra cycle to copy acc into alu_out.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] acc_sum;

  assign acc_sum = mplr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_out   <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              acc_reg   <= '0;
              mcand_reg <= num1;
              mplr_reg  <= num2;
              cnt_reg   <= '0;
              state_reg <= MUL;
            end else begin
              alu_out   <= sc_result;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        MUL: begin
          // Fixed WIDTH iterations: there is no early exit when mplr runs
          // out of ones, so the latency does not depend on the data.
          acc_reg   <= acc_sum;
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
          cnt_reg   <= cnt_reg + SHW'(1);
          if (cnt_reg == CNT_LAST) begin
            alu_out   <= acc_sum;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end

        DONE: begin
          // alu_out is only written in IDLE/MUL, so it holds steady here
          // until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH = 32).
// Directed vector table, hand-written multi-cycle sequences and randomized
// requests checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [1:0]    num1_cs;
  logic [1:0]    num2_cs;
  logic [W-1:0]  pc_din;
  logic [W-1:0]  im_din;
  logic [W-1:0]  reg_din0;
  logic [W-1:0]  reg_din1;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_out;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .num1_cs  (num1_cs),
    .num2_cs  (num2_cs),
    .pc_din   (pc_din),
    .im_din   (im_din),
    .reg_din0 (reg_din0),
    .reg_din1 (reg_din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [1:0]   cs1;
    logic [1:0]   cs2;
    logic [W-1:0] pc;
    logic [W-1:0] im;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] exp_v;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: results derived from the operation definitions with
  // plain arithmetic on wide integers.
  function automatic logic [W-1:0] pick(input logic [1:0] cs, input logic [W-1:0] pc,
                                        input logic [W-1:0] im, input logic [W-1:0] r0,
                                        input logic [W-1:0] r1);
    case (cs)
      2'd0:    return r0;
      2'd1:    return im;
      2'd2:    return pc;
      default: return r1;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int unsigned s = ub % W;
    longint unsigned p;
    logic [W-1:0] fill;
    case (o)
      4'd0: begin p = ua + ub; return p[W-1:0]; end
      4'd1: begin p = ua - ub; return p[W-1:0]; end
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: begin p = ua * (64'd1 << s); return p[W-1:0]; end
      4'd6: begin p = ua / (64'd1 << s); return p[W-1:0]; end
      4'd7: begin
        // Arithmetic shift: logical shift plus the sign copied into the
        // vacated top bits.
        p = ua / (64'd1 << s);
        fill = a[W-1] ? ~({W{1'b1}} >> s) : '0;
        return p[W-1:0] | fill;
      end
      4'd8: return (sa < sb) ? 1 : 0;
      4'd9: return (ua < ub) ? 1 : 0;
      4'd10: begin p = ua * ub; return p[W-1:0]; end
      default: return '0;
    endcase
  endfunction

  // Apply one request, measure latency in edges from the acceptance edge
  // (inclusive) to out_valid, check result and the return to idle.
  task automatic run_op(input string name, input logic [3:0] o, input logic [1:0] c1,
                        input logic [1:0] c2, input logic [W-1:0] pc, input logic [W-1:0] im,
                        input logic [W-1:0] r0, input logic [W-1:0] r1,
                        input logic [W-1:0] exp_v);
    int lat;
    int exp_lat;
    exp_lat = (o == 4'd10) ? W + 1 : 1;
    @(negedge clk);
    op = o; num1_cs = c1; num2_cs = c2;
    pc_din = pc; im_din = im; reg_din0 = r0; reg_din1 = r1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk({name, "_rdy"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Sources are don't-care after acceptance.
    pc_din = $urandom; im_din = $urandom; reg_din0 = $urandom; reg_din1 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, W'(lat), W'(exp_lat));
    chk({name, "_res"}, alu_out, exp_v);
    $display("op=%0d a=%h b=%h result=%h latency=%0d", o, pick(c1, pc, im, r0, r1),
             pick(c2, pc, im, r0, r1), alu_out, lat);
    @(posedge clk); #1;
    chk({name, "_idle_rdy"}, W'(in_ready), W'(1));
    chk({name, "_idle_vld"}, W'(out_valid), W'(0));
  endtask

  initial begin
    vecs[0]  = '{4'd0,  2'd2, 2'd1, 32'h100, 32'h4, 32'h0, 32'h0, 32'h104};
    vecs[1]  = '{4'd0,  2'd0, 2'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0};
    vecs[2]  = '{4'd1,  2'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF};
    vecs[3]  = '{4'd7,  2'd0, 2'd1, 32'h0, 32'h24, 32'h80000000, 32'h0, 32'hF8000000};
    vecs[4]  = '{4'd6,  2'd0, 2'd1, 32'h0, 32'h24, 32'h80000000, 32'h0, 32'h08000000};
    vecs[5]  = '{4'd8,  2'd0, 2'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1};
    vecs[6]  = '{4'd9,  2'd0, 2'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0};
    vecs[7]  = '{4'd10, 2'd0, 2'd1, 32'h0, 32'h9, 32'h12345678, 32'h0, 32'hA3D70A38};
    vecs[8]  = '{4'd10, 2'd0, 2'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
    vecs[9]  = '{4'd13, 2'd0, 2'd3, 32'h0, 32'h0, 32'h1234, 32'h5678, 32'h0};
    vecs[10] = '{4'd2,  2'd0, 2'd3, 32'h0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[11] = '{4'd3,  2'd0, 2'd3, 32'h0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[12] = '{4'd4,  2'd0, 2'd3, 32'h0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[13] = '{4'd5,  2'd2, 2'd1, 32'h1, 32'd31, 32'h0, 32'h0, 32'h80000000};
    vecs[14] = '{4'd1,  2'd3, 2'd0, 32'h0, 32'h0, 32'd3, 32'd10, 32'd7};

    // Reset and idle
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0;
    num1_cs = '0; num2_cs = '0; pc_din = '0; im_din = '0; reg_din0 = '0; reg_din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_alu_out", alu_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].cs1, vecs[i].cs2, vecs[i].pc,
             vecs[i].im, vecs[i].r0, vecs[i].r1, vecs[i].exp_v);
    end

    // MUL with in_valid activity while busy: must be ignored.
    begin
      int lat;
      @(negedge clk);
      op = 4'd10; num1_cs = 2'd0; num2_cs = 2'd3; reg_din0 = 32'd1000; reg_din1 = 32'd77;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      op = 4'd0; reg_din0 = 32'hDEAD; reg_din1 = 32'hBEEF;
      lat = 1;
      for (int k = 0; k < 10; k++) begin
        in_valid = (k % 2 == 0);
        chk("busy_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        lat++;
      end
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("busy_mul_lat", W'(lat), W'(W + 1));
      chk("busy_mul_res", alu_out, 32'd77000);
      $display("op=10 a=%h b=%h result=%h latency=%0d (busy pulses)", 32'd1000, 32'd77, alu_out, lat);
      @(posedge clk); #1;
      chk("busy_idle", W'(in_ready), W'(1));
    end

    // Backpressure: hold out_ready low for 5 cycles after the result.
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'd0; num1_cs = 2'd0; num2_cs = 2'd3; reg_din0 = 32'd7; reg_din1 = 32'd8;
    in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd4; reg_din0 = 32'hAAAA;  // keep in_valid high: must not be latched
    chk("bp_valid", W'(out_valid), W'(1));
    chk("bp_res", alu_out, 32'd15);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_res", alu_out, 32'd15);
      chk("bp_hold_rdy", W'(in_ready), W'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rdy", W'(in_ready), W'(1));
    chk("bp_release_vld", W'(out_valid), W'(0));
    $display("op=0 a=%h b=%h result=%h backpressure 5 cycles", 32'd7, 32'd8, 32'd15);

    // Reset in the middle of a MUL.
    @(negedge clk);
    op = 4'd10; num1_cs = 2'd0; num2_cs = 2'd3; reg_din0 = 32'hFFFF; reg_din1 = 32'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", W'(in_ready), W'(1));
    chk("midrst_vld", W'(out_valid), W'(0));
    chk("midrst_out", alu_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < W + 8; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("midrst_no_valid", W'(seen), W'(0));
    end
    $display("op=10 reset asserted mid-operation, result discarded");
    run_op("post_rst_add", 4'd0, 2'd0, 2'd3, 0, 0, 32'd2, 32'd3, 32'd5);

    // Randomized requests against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [3:0]   ro;
      logic [1:0]   c1, c2;
      logic [W-1:0] pc, im, r0, r1;
      ro = 4'($urandom_range(0, 15));
      c1 = 2'($urandom_range(0, 3));
      c2 = 2'($urandom_range(0, 3));
      pc = $urandom; im = $urandom; r0 = $urandom; r1 = $urandom;
      if (n % 4 == 0) im = 32'($urandom_range(0, 40));
      run_op($sformatf("rnd%0d", n), ro, c1, c2, pc, im, r0, r1,
             model(ro, pick(c1, pc, im, r0, r1), pick(c2, pc, im, r0, r1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
